// File: rtl/fetch_ir_unit.sv
// rtl/fetch_ir_unit.sv - fetch stage: PC, instruction memory req/ack handshake, IR and decoded fields
module fetch_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic [5:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [13:0] imm14,
    output logic [23:0] imm24
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Last wait-counter value before the fetch is declared lost.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      stateNext;
    logic        accept;
    logic        complete;
    logic        timedOut;
    logic        loadPending;
    logic [7:0]  waitCnt;
    logic [31:0] pcTarget;

    // Branch targets are always word aligned; the low two bits are dropped.
    assign pcTarget = pc_next & 32'hFFFF_FFFC;

    assign mem_req = (state == REQ);
    assign busy    = (state != IDLE);

    assign opcode = ir[31:26];
    assign rd     = ir[25:22];
    assign rs1    = ir[21:18];
    assign rs2    = ir[17:14];
    assign imm14  = ir[13:0];
    assign imm24  = ir[23:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and per-cycle transaction events; an ack in REQ completes like an ack in WAIT.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        complete  = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch) begin
                    accept    = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else if (waitCnt == LAST_CNT) begin
                    timedOut  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: fetch address, IR capture, error flag, wait counter and PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            ir          <= 32'h0;
            ir_valid    <= 1'b0;
            mem_addr    <= 32'h0;
            fetch_err   <= 1'b0;
            waitCnt     <= 8'h0;
            loadPending <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr    <= pc;
                ir_valid    <= 1'b0;
                fetch_err   <= 1'b0;
                waitCnt     <= 8'h0;
                loadPending <= pc_load;
            end
            if (busy && !complete && !timedOut) begin
                waitCnt <= waitCnt + 8'd1;
            end
            if (busy && pc_load) begin
                loadPending <= 1'b1;
            end
            if (complete) begin
                ir       <= mem_rdata;
                ir_valid <= 1'b1;
            end
            if (timedOut) begin
                fetch_err <= 1'b1;
            end
            // A load from control always wins; otherwise a clean completion steps past the fetched word.
            if (pc_load) begin
                pc <= pcTarget;
            end else if (complete && !loadPending) begin
                pc <= mem_addr + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb/tb_fetch_ir_unit.sv - randomized and directed bench for fetch_ir_unit against a transaction-level model
module tb_fetch_ir_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        fetch;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;
    logic [5:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [13:0] imm14;
    logic [23:0] imm24;

    fetch_ir_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .pc_load(pc_load), .pc_next(pc_next),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm14(imm14), .imm24(imm24)
    );

    int checks = 0;
    int errors = 0;
    bit compareOn = 0;

    // Model: one outstanding transaction, its age in cycles since acceptance, and whether control redirected the PC.
    logic [31:0] mPc, mIr, mAddr;
    logic        mValid, mErr, mInFlight, mLoaded;
    int          mAge;
    int          ackPlan;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RPC; mIr = 0; mAddr = 0; mValid = 0; mErr = 0;
        mInFlight = 0; mLoaded = 0; mAge = 0; ackPlan = 0;
    endtask

    // One clock edge of the specified behaviour, evaluated on the inputs present at that edge.
    task automatic modelStep();
        if (!mInFlight) begin
            if (fetch) begin
                mInFlight = 1; mAge = 0; mAddr = mPc; mValid = 0; mErr = 0;
                mLoaded = pc_load;
                ackPlan = $urandom_range(0, TMO + 1);
            end
        end else if (mem_ack) begin
            mIr = mem_rdata; mValid = 1; mInFlight = 0;
            if (!mLoaded) mPc = mAddr + 32'd4;
        end else if (mAge == TMO - 1) begin
            mErr = 1; mInFlight = 0;
        end else begin
            mAge++;
        end
        if (pc_load) begin
            mPc = pc_next & 32'hFFFF_FFFC;
            if (mInFlight) mLoaded = 1;
        end
    endtask

    task automatic step(input logic f, input logic pl, input logic [31:0] pn,
                        input logic ack, input logic [31:0] rdat);
        fetch = f; pc_load = pl; pc_next = pn; mem_ack = ack; mem_rdata = rdat;
        @(posedge clk);
        modelStep();
        #1;
        fetch = 0; pc_load = 0; mem_ack = 0;
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        modelReset();
        #3;
        rst_n = 1'b1;
    endtask

    // Every cycle, all outputs must equal what the model says.
    always @(negedge clk) begin
        if (compareOn && rst_n) begin
            chk("mem_req", {31'b0, mem_req}, {31'b0, (mInFlight && mAge == 0)});
            chk("busy", {31'b0, busy}, {31'b0, mInFlight});
            chk("mem_addr", mem_addr, mAddr);
            chk("pc", pc, mPc);
            chk("ir", ir, mIr);
            chk("ir_valid", {31'b0, ir_valid}, {31'b0, mValid});
            chk("fetch_err", {31'b0, fetch_err}, {31'b0, mErr});
            chk("opcode", {26'b0, opcode}, mIr >> 26);
            chk("rd", {28'b0, rd}, (mIr >> 22) % 16);
            chk("rs1", {28'b0, rs1}, (mIr >> 18) % 16);
            chk("rs2", {28'b0, rs2}, (mIr >> 14) % 16);
            chk("imm14", {18'b0, imm14}, mIr % 32'h4000);
            chk("imm24", {8'b0, imm24}, mIr % 32'h0100_0000);
        end
    end

    initial begin
        int n;
        int busyCnt;
        int reqCnt;
        logic f, pl, ack;

        rst_n = 1'b0; fetch = 0; pc_load = 0; pc_next = 0; mem_ack = 0; mem_rdata = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compareOn = 1;

        // Reset state and a zero-wait fetch.
        chk("reset pc", pc, 32'h100);
        chk("reset ir", ir, 32'h0);
        chk("reset ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("t1 mem_req", {31'b0, mem_req}, 32'h1);
        step(0, 0, 0, 1, 32'hABCD_1234);
        chk("t1 ir", ir, 32'hABCD_1234);
        chk("t1 imm14", {18'b0, imm14}, 32'h1234);
        chk("t1 imm24", {8'b0, imm24}, 32'h00CD_1234);
        chk("t1 opcode", {26'b0, opcode}, 32'h2A);
        chk("t1 ir_valid", {31'b0, ir_valid}, 32'h1);
        chk("t1 pc", pc, 32'h104);

        // Ack delayed by five cycles, with fetch pulses while busy.
        busyCnt = 0; reqCnt = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            busyCnt += int'(busy); reqCnt += int'(mem_req);
            step(1, 0, 0, 0, 0);
        end
        busyCnt += int'(busy); reqCnt += int'(mem_req);
        step(0, 0, 0, 1, 32'h1357_9BDF);
        busyCnt += int'(busy); reqCnt += int'(mem_req);
        chk("t2 busy cycles", busyCnt, 32'd6);
        chk("t2 req cycles", reqCnt, 32'd1);
        chk("t2 ir", ir, 32'h1357_9BDF);
        chk("t2 pc", pc, 32'h108);

        // No ack: timeout, then a retry of the same address.
        step(1, 0, 0, 0, 0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step(0, 0, 0, 0, 0);
        end
        chk("t3 wait cycles", n, 32'd16);
        chk("t3 fetch_err", {31'b0, fetch_err}, 32'h1);
        chk("t3 ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("t3 pc", pc, 32'h108);
        step(1, 0, 0, 0, 0);
        chk("t3 retry addr", mem_addr, 32'h108);
        chk("t3 err cleared", {31'b0, fetch_err}, 32'h0);
        step(0, 0, 0, 1, 32'h0000_0001);

        // Redirect during WAIT.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_2003, 0, 0);
        step(0, 0, 0, 1, 32'h0202_0202);
        chk("t4 fetch addr", mem_addr, 32'h10C);
        chk("t4 pc", pc, 32'h2000);

        // PC wraps past the top of the address space.
        step(0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("t5 loaded pc", pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0BAD_F00D);
        chk("t5 pc wrap", pc, 32'h0);

        // Reset mid-fetch, then a stale ack.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        resetPulse();
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t6 pc", pc, 32'h100);
        chk("t6 ir", ir, 32'h0);
        chk("t6 ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("t6 busy", {31'b0, busy}, 32'h0);

        // Random traffic: fetches, redirects, ack latencies up to beyond the timeout, stray acks, resets.
        for (int c = 0; c < 3000; c++) begin
            f  = ($urandom_range(0, 3) == 0);
            pl = ($urandom_range(0, 9) == 0);
            if (mInFlight) ack = (mAge == ackPlan);
            else           ack = ($urandom_range(0, 7) == 0);
            step(f, pl, $urandom, ack, $urandom);
            if ($urandom_range(0, 599) == 0) resetPulse();
        end

        compareOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
Fetch stage of the multicycle core. Holds the PC and runs a req/ack read handshake to instruction memory. Latches the returned word into the instruction register (IR) and presents decoded fields to the downstream stages: imm14 and imm24 go raw to the 14-bit and 24-bit sign extenders, and register and opcode fields go to control and the register file. Also owns the PC update: sequential increment, or a load from control for branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset (low 2 bits must be 0)
TIMEOUT, 16, max cycles to wait for mem_ack before flagging fetch_err (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch  in  1  control pulse: start an instruction fetch
pc_load  in  1  control: load pc_next into PC
pc_next  in  32  branch/jump target; bits [1:0] ignored, forced 0
mem_req  out  1  read request to instruction memory
mem_addr  out  32  word-aligned fetch address
mem_ack  in  1  memory response valid; mem_rdata sampled this cycle
mem_rdata  in  32  instruction word
pc  out  32  current PC
ir  out  32  instruction register
ir_valid  out  1  IR holds a completed fetch
busy  out  1  fetch in flight (REQ or WAIT)
fetch_err  out  1  sticky timeout flag; cleared only by the next accepted fetch or by reset
opcode  out  6  ir[31:26]
rd  out  4  ir[25:22]
rs1  out  4  ir[21:18]
rs2  out  4  ir[17:14]
imm14  out  14  ir[13:0], to sign_extend14
imm24  out  24  ir[23:0], to sign_extend24

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; ir=0; ir_valid=0; mem_req=0; mem_addr=0; busy=0; fetch_err=0; wait counter=0. Reset mid-fetch abandons the transaction; a late mem_ack after reset is ignored because the state is IDLE.
- Field outputs are pure slices of the ir register: no extra latency, and no sign extension here.
- FSM states: IDLE, REQ, WAIT.
  - IDLE + fetch: mem_addr←pc, mem_req←1, ir_valid←0, fetch_err←0, counter←0, next state REQ.
  - REQ: mem_req=1 for exactly this one cycle. If mem_ack=1 in this cycle, complete as in WAIT. Otherwise go to WAIT; mem_req drops to 0.
  - WAIT, mem_ack=1: ir←mem_rdata, ir_valid←1, next state IDLE; PC update applied per the rules below.
  - WAIT, no ack: counter increments each cycle. When the counter reaches TIMEOUT-1 with no ack, fetch_err←1, ir unchanged, ir_valid stays 0, pc unchanged, next state IDLE.
- busy=1 in REQ and WAIT.
- Fetch latency: earliest ir_valid is 2 cycles after the fetch edge (fetch at cycle 0, REQ at cycle 1 with ack, ir_valid at cycle 2).
- fetch while busy: ignored; no queueing.
- PC update rules:
  - pc_load with no fetch in flight: pc←{pc_next[31:2],2'b00} on the next edge.
  - Fetch completes with no pc_load since the fetch was accepted: pc←mem_addr+4. Wraps modulo 2^32: 32'hFFFF_FFFC→0.
  - pc_load during REQ/WAIT: the value is captured in a pending register; pc itself updates immediately. On completion pc keeps the loaded value and the +4 is suppressed. The in-flight fetch still uses the latched mem_addr.
  - pc_load in the same cycle as completion: the loaded value wins.
  - pc_load in the same cycle as fetch in IDLE: this fetch uses the old pc; pc←pc_next; the +4 is suppressed on completion.
- Timeout: pc is not advanced, so a retry fetches the same address.
- mem_ack outside REQ/WAIT: ignored.

Test Plan:
1. Reset with RESET_PC=0x100 → pc=0x100, ir=0, ir_valid=0, mem_req=0. Pulse fetch; ack in the REQ cycle with rdata=0xABCD_1234 → ir=0xABCD1234, imm14=0x1234, imm24=0xCD1234, opcode=0x2A, ir_valid one cycle after ack, pc=0x104.
2. Fetch with ack delayed 5 cycles, TIMEOUT=16 → mem_req high exactly 1 cycle, busy high 6 cycles, ir latched, pc+=4. Extra fetch pulses during busy are ignored (exactly one transaction).
3. No ack, TIMEOUT=16 → fetch_err=1 after 16 cycles of waiting, pc unchanged, ir_valid=0. Next fetch clears fetch_err and reads the same mem_addr.
4. pc_load=1, pc_next=0x2003 during WAIT, then ack → fetch used the old address; final pc=0x2000, not old+4.
5. pc=0xFFFF_FFFC, fetch completes → pc=0x0000_0000.
6. rst_n low during WAIT, then mem_ack pulse after release → remains IDLE, ir=0, ir_valid=0, pc=RESET_PC.
